// File: rtl/gf16_inv_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^4) inverter.
interface gf16_inv_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/gf16_inv_seq.sv
// Sequential GF(2^4) inverter, a^-1 = a^14, over x^4+x+1.
// One shared field multiplier walks a -> a^2 -> a^3 -> a^6 -> a^7 -> a^14.
module FFMul_K4_Q2 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);
    logic [3:0] sh;

    always_comb begin
        p_o = 4'h0;
        sh  = a_i;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i])
                p_o = p_o ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
    end
endmodule

module gf16_inv_seq #(
    parameter bit ZERO_FAST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    gf16_inv_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ1  = 3'd1,
        MUL1 = 3'd2,
        SQ2  = 3'd3,
        MUL2 = 3'd4,
        SQ3  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    logic [3:0] mul_a, mul_b, prod;
    logic       idle, take, zero_skip, xfer;

    FFMul_K4_Q2 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign idle      = (state_q == IDLE);
    assign take      = idle && bus.in_valid;
    assign zero_skip = ZERO_FAST && (bus.in_data == 4'h0);
    assign xfer      = out_valid_q && bus.out_ready;

    // rst_n only gates the visible ready; internal accept uses the state
    assign bus.in_ready  = rst_n && idle;
    assign bus.busy      = !idle;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= 4'h0;
            acc_q       <= 4'h0;
            out_data_q  <= 4'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take)
                    state_d = zero_skip ? DONE : SQ1;
            end
            SQ1:  state_d = MUL1;
            MUL1: state_d = SQ2;
            SQ2:  state_d = MUL2;
            MUL2: state_d = SQ3;
            SQ3:  state_d = DONE;
            DONE: begin
                if (xfer)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_a_d      = op_a_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mul_a       = acc_q;
        mul_b       = acc_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    op_a_d = bus.in_data;
                    acc_d  = zero_skip ? 4'h0 : bus.in_data;
                end
            end
            SQ1, SQ2: begin
                acc_d = prod;
            end
            MUL1, MUL2: begin
                mul_b = op_a_q;
                acc_d = prod;
            end
            SQ3: begin
                acc_d       = prod;
                out_data_d  = prod;
                out_valid_d = 1'b1;
            end
            DONE: begin
                // zero shortcut arrives here without a result posted yet
                if (!out_valid_q) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule
